// File: rtl/chacha_inv_perm.sv
// Iterative inverse ChaCha permutation: undoes ROUNDS rounds (no feed-forward),
// one inverse quarter-round per clock, diagonals before columns within each double-round.
module chacha_inv_perm #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [511:0] state_in,
    output logic         ready,
    output logic [511:0] state_out,
    output logic         state_out_valid
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [3:0] DrLast = 4'(ROUNDS / 2 - 1);

    state_e       st_q;
    logic [511:0] work_q, work_d;
    logic [2:0]   qr_ctr_q;
    logic [3:0]   dr_ctr_q;
    logic         ready_q, valid_q;

    logic [31:0] cur [16];
    logic [31:0] nxt [16];
    logic [3:0]  ia, ib, ic, id;
    logic [31:0] a0, b0, c0, d0;
    logic [31:0] a1, b1, c1, d1;
    logic [31:0] a2, b2, c2, d2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        unique case (qr_ctr_q)
            3'd0: {ia, ib, ic, id} = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd1: {ia, ib, ic, id} = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd2: {ia, ib, ic, id} = {4'd2, 4'd7, 4'd8,  4'd13};
            3'd3: {ia, ib, ic, id} = {4'd3, 4'd4, 4'd9,  4'd14};
            3'd4: {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd5: {ia, ib, ic, id} = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd6: {ia, ib, ic, id} = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd7: {ia, ib, ic, id} = {4'd3, 4'd7, 4'd11, 4'd15};
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cur[i] = work_q[511 - 32 * i -: 32];
        end
        a0 = cur[ia];
        b0 = cur[ib];
        c0 = cur[ic];
        d0 = cur[id];
        // Forward quarter-round steps undone in reverse order.
        b1 = rotr(b0, 7) ^ c0;
        c1 = c0 - d0;
        d1 = rotr(d0, 8) ^ a0;
        a1 = a0 - b1;
        b2 = rotr(b1, 12) ^ c1;
        c2 = c1 - d1;
        d2 = rotr(d1, 16) ^ a1;
        a2 = a1 - b2;
        for (int i = 0; i < 16; i++) begin
            nxt[i] = cur[i];
        end
        nxt[ia] = a2;
        nxt[ib] = b2;
        nxt[ic] = c2;
        nxt[id] = d2;
        work_d = '0;
        for (int i = 0; i < 16; i++) begin
            work_d[511 - 32 * i -: 32] = nxt[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= StIdle;
            work_q   <= '0;
            qr_ctr_q <= '0;
            dr_ctr_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (init) begin
                        work_q   <= state_in;
                        qr_ctr_q <= '0;
                        dr_ctr_q <= '0;
                        valid_q  <= 1'b0;
                        ready_q  <= 1'b0;
                        st_q     <= StBusy;
                    end
                end
                StBusy: begin
                    work_q   <= work_d;
                    qr_ctr_q <= qr_ctr_q + 3'd1;
                    if (qr_ctr_q == 3'd7) begin
                        if (dr_ctr_q == DrLast) begin
                            dr_ctr_q <= '0;
                            valid_q  <= 1'b1;
                            ready_q  <= 1'b1;
                            st_q     <= StIdle;
                        end else begin
                            dr_ctr_q <= dr_ctr_q + 4'd1;
                        end
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign ready           = ready_q;
    assign state_out       = work_q;
    assign state_out_valid = valid_q;

endmodule

// File: tb/tb_chacha_inv_perm.sv
// Directed bench for chacha_inv_perm: reset, RFC 7539 known answer, busy/back-to-back
// behaviour at ROUNDS=20, and forward-model round trips at ROUNDS=8.
module tb_chacha_inv_perm;

    logic         clk = 1'b0;
    logic         reset;
    logic         init20, init8;
    logic [511:0] in20, in8, out20, out8;
    logic         rdy20, rdy8, val20, val8;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    chacha_inv_perm #(.ROUNDS(20)) dut20 (
        .clk             (clk),
        .reset           (reset),
        .init            (init20),
        .state_in        (in20),
        .ready           (rdy20),
        .state_out       (out20),
        .state_out_valid (val20)
    );

    chacha_inv_perm #(.ROUNDS(8)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .init            (init8),
        .state_in        (in8),
        .ready           (rdy8),
        .state_out       (out8),
        .state_out_valid (val8)
    );

    localparam logic [511:0] KatIn = {
        32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
        32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
        32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
        32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};
    localparam logic [511:0] KatOut = {
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] fqr(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Forward ChaCha permutation without feed-forward.
    function automatic logic [511:0] fwd(input logic [511:0] s, input int rounds);
        logic [31:0]  w [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) w[i] = s[511 - 32 * i -: 32];
        for (int k = 0; k < rounds / 2; k++) begin
            {w[0], w[4], w[8],  w[12]} = fqr(w[0], w[4], w[8],  w[12]);
            {w[1], w[5], w[9],  w[13]} = fqr(w[1], w[5], w[9],  w[13]);
            {w[2], w[6], w[10], w[14]} = fqr(w[2], w[6], w[10], w[14]);
            {w[3], w[7], w[11], w[15]} = fqr(w[3], w[7], w[11], w[15]);
            {w[0], w[5], w[10], w[15]} = fqr(w[0], w[5], w[10], w[15]);
            {w[1], w[6], w[11], w[12]} = fqr(w[1], w[6], w[11], w[12]);
            {w[2], w[7], w[8],  w[13]} = fqr(w[2], w[7], w[8],  w[13]);
            {w[3], w[4], w[9],  w[14]} = fqr(w[3], w[4], w[9],  w[14]);
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[511 - 32 * i -: 32] = w[i];
        return r;
    endfunction

    task automatic drive(input bit r8, input logic go, input logic [511:0] v);
        if (r8) begin
            init8 = go;
            in8   = v;
        end else begin
            init20 = go;
            in20   = v;
        end
    endtask

    // Issues init in the current cycle if ready (bounded wait otherwise); optional
    // stray inits at busy cycles 10 and 40 with a different vector.
    task automatic run(input bit r8, input logic [511:0] vin, input bit poke,
                       output logic [511:0] vout);
        int n;
        int lim;
        bit busy_ok;
        lim = r8 ? 32 : 80;
        n = 0;
        while (!(r8 ? rdy8 : rdy20) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        drive(r8, 1'b1, vin);
        @(posedge clk); #1;
        drive(r8, 1'b0, vin);
        chk("valid_clr", 512'(r8 ? val8 : val20), 512'(0));
        n = 0;
        busy_ok = 1'b1;
        while (!(r8 ? val8 : val20) && n < 200) begin
            if (r8 ? rdy8 : rdy20) busy_ok = 1'b0;
            if (poke && (n == 10 || n == 40)) drive(r8, 1'b1, ~vin);
            else drive(r8, 1'b0, vin);
            @(posedge clk); #1;
            n++;
        end
        drive(r8, 1'b0, vin);
        chk("latency", 512'(n), 512'(lim));
        chk("busy_ready", 512'(busy_ok), 512'(1));
        vout = r8 ? out8 : out20;
    endtask

    initial begin
        logic [511:0] r, x;
        reset  = 1'b1;
        init20 = 1'b0;
        init8  = 1'b0;
        in20   = '0;
        in8    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 512'(rdy20), 512'(1));
        chk("rst_valid", 512'(val20), 512'(0));
        chk("rst_out", out20, '0);
        chk("rst_ready8", 512'(rdy8), 512'(1));
        chk("rst_out8", out8, '0);
        reset = 1'b0;

        // Reset 30 cycles into a computation.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, KatIn);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, KatIn);
        repeat (29) @(posedge clk);
        #1;
        chk("mid_busy", 512'(rdy20), 512'(0));
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 512'(rdy20), 512'(1));
        chk("mid_rst_valid", 512'(val20), 512'(0));
        chk("mid_rst_out", out20, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        run(1'b0, '0, 1'b0, r);
        chk("zero_vec", r, '0);
        run(1'b0, KatIn, 1'b0, r);
        chk("kat", r, KatOut);
        run(1'b0, KatIn, 1'b1, r);
        chk("busy_kat", r, KatOut);

        // Back-to-back: each run issues init in the first ready cycle.
        x = {16{32'hdeadbeef}} ^ KatOut;
        run(1'b0, fwd(x, 20), 1'b0, r);
        chk("b2b_first", r, x);
        run(1'b0, KatIn, 1'b0, r);
        chk("b2b_second", r, KatOut);

        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 16; i++) x[511 - 32 * i -: 32] = $urandom;
            if (k == 0) x = '1;
            run(1'b1, fwd(x, 8), 1'b0, r);
            chk("round_trip8", r, x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chacha_inv_perm.md
# chacha_inv_perm

Iterative inverse of the ChaCha block permutation. It takes a 512-bit state that has been through ROUNDS rounds, before the feed-forward addition, and recovers the original input state. Each clock cycle it applies one inverse quarter-round. It is the decode-direction counterpart of the combinational quarter-round datapath and is used for cipher self-test and known-answer checking next to the forward core.

## Interface
- ROUNDS, 20: number of rounds to undo; even, 8..20 inclusive.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  start pulse; sampled only while ready=1.
- state_in  input  512  permuted state; word 0 in [511:480], word 15 in [31:0].
- ready  output  1  high when idle and able to accept init.
- state_out  output  512  recovered state, same word ordering as state_in.
- state_out_valid  output  1  state_out holds a completed result.

## Operation
- Inverse quarter-round on (a,b,c,d), with 32-bit wrapping arithmetic and right rotations (>>>), applied in this order:
  - b = (b>>>7) ^ c; c = c - d;
  - d = (d>>>8) ^ a; a = a - b;
  - b = (b>>>12) ^ c; c = c - d;
  - d = (d>>>16) ^ a; a = a - b.
- Each step uses the values updated by the preceding steps.
- One inverse double-round is 8 inverse quarter-rounds, one per cycle, selected by a 3-bit qr_ctr:
  - qr_ctr 0..3 (diagonals): (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - qr_ctr 4..7 (columns): (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
- A dr_ctr counts double-rounds from 0 to ROUNDS/2-1.
- FSM states:
  - IDLE: ready=1. On init, load state_in into the working register, clear qr_ctr and dr_ctr, clear state_out_valid, and go to BUSY.
  - BUSY: ready=0. Each cycle, apply the selected inverse quarter-round to the working register and increment qr_ctr, which wraps 7 to 0. On the wrap, increment dr_ctr.
  - On the cycle where qr_ctr=7 and dr_ctr=ROUNDS/2-1, apply the final quarter-round, set state_out_valid=1, and return to IDLE.
- state_out is driven directly from the working register. It is meaningful only while state_out_valid=1.
- state_out_valid stays high until the next accepted init or reset.
- init while BUSY is ignored. No queuing, and the in-flight computation is unaffected.
- A new init while state_out_valid=1 is accepted and clears state_out_valid on the same edge.
- Reset at any time, including mid-computation, forces IDLE immediately and discards any partial result.
- Reset values: ready=1, state_out_valid=0, state_out=0 (working register cleared), qr_ctr=0, dr_ctr=0.

## Timing
- Sampling: init is sampled at edge E0. Inverse quarter-rounds are applied at edges E1..E(4*ROUNDS).
- Completion: state_out_valid and ready rise after edge E(4*ROUNDS).
- Latency: 4*ROUNDS cycles from the init edge to valid. That is 80 cycles for ROUNDS=20 and 32 for ROUNDS=8.
- Back-to-back throughput: init may be reasserted in the first cycle ready=1, giving one result every 4*ROUNDS cycles.
- Critical path: one inverse quarter-round, which is 4 subtractors and 4 XOR/rotate stages in series, plus a 16:4 word-select mux and write-back.
- No combinational path from init or state_in to any output.

## Test plan
- Reset: assert reset mid-BUSY at cycle 30 -> ready=1, state_out_valid=0, state_out=0 immediately. The next init then completes normally 80 cycles later.
- Zero vector: ROUNDS=20, state_in all zeros, init -> after 80 cycles state_out_valid=1 and state_out all zeros.
- Known answer: ROUNDS=20, state_in = RFC 7539 §2.3.2 "state after 20 rounds" (word0=0x837778ab, word1=0xe238d763, …), init -> after 80 cycles state_out equals the §2.3.2 initial state (word0=0x61707865, word1=0x3320646e, word2=0x79622d32, word3=0x6b206574, …).
- Busy protection: pulse init again at cycles 10 and 40 with a different state_in -> ignored. The result and the 80-cycle latency are unchanged, and ready stays 0 throughout.
- Back-to-back: issue init the same cycle ready rises, using two distinct vectors -> two correct results 80 cycles apart. state_out_valid drops on the second accepted init.
- Round-trip: ROUNDS=8, random state_in X run through the forward core (8 rounds, no feed-forward), then fed to this block -> state_out equals X after 32 cycles. Repeat for 1000 random vectors.
